// File: rtl/multu_hilo_stage_if.sv
// Handshake and data bundle between the issue logic and the MULTU/HI/LO stage.
// The slave side is the stage. The master side is the upstream/downstream logic.
interface multu_hilo_stage_if #(
  parameter int WIDTH = 32
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [5:0]       inSignal;
  logic [WIDTH-1:0] aluOut;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] dataOut;
  logic             busy;

  modport slave (
    input  inValid, a, b, inSignal, aluOut, outReady,
    output inReady, outValid, dataOut, busy
  );

  modport master (
    output inValid, a, b, inSignal, aluOut, outReady,
    input  inReady, outValid, dataOut, busy
  );
endinterface

// File: rtl/multu_hilo_stage.sv
// Write-back stage with a shift-add unsigned multiplier (MULTU) feeding HI/LO.
// It also forwards the ALU result for every other funct code.
module multu_hilo_stage #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  multu_hilo_stage_if.slave     bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready;
  logic             accept;
  logic [WIDTH:0]   sum;

  always_comb begin
    in_ready = (state_q == IDLE) && (!out_valid_q || bus.outReady);
    accept   = bus.inValid && in_ready;
  end

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mcand_d     = mcand_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    sum         = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

    case (state_q)
      MUL: begin
        // {sum, LO} shifted right by one: the carry lands in HI, the sum LSB in LO.
        hi_d    = sum[WIDTH:1];
        lo_d    = {sum[0], lo_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        if (out_valid_q && bus.outReady) begin
          out_valid_d = 1'b0;
        end
        if (accept) begin
          case (bus.inSignal)
            FUNCT_MULTU: begin
              hi_d        = '0;
              lo_d        = bus.b;
              mcand_d     = bus.a;
              count_d     = '0;
              out_valid_d = 1'b0;
              state_d     = MUL;
            end
            FUNCT_MFHI: begin
              data_out_d  = hi_q;
              out_valid_d = 1'b1;
            end
            FUNCT_MFLO: begin
              data_out_d  = lo_q;
              out_valid_d = 1'b1;
            end
            default: begin
              data_out_d  = bus.aluOut;
              out_valid_d = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      mcand_q     <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mcand_q     <= mcand_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid_q;
  assign bus.dataOut  = data_out_q;
  assign bus.busy     = (state_q == MUL);

endmodule
